// File: rtl/gray_up_down_counter_if.sv
// Control and data bundle for the Gray up/down counter.
// Master drives the step/load controls; slave returns the registered count, Gray code and tc.
interface gray_up_down_counter_if #(
  parameter int N = 8
);
  logic         en;
  logic         up;
  logic         load;
  logic [N-1:0] load_bin;
  logic [N-1:0] bin;
  logic [N-1:0] g;
  logic         tc;

  modport master (
    output en, up, load, load_bin,
    input  bin, g, tc
  );

  modport slave (
    input  en, up, load, load_bin,
    output bin, g, tc
  );
endinterface

// File: rtl/gray_up_down_counter.sv
// Registered N-bit up/down counter with a registered Gray-code copy and a terminal-count pulse.
// Latency: one cycle from sampled en/load to bin/g/tc. No backpressure; one step per enabled cycle.
module gray_up_down_counter #(
  parameter int N    = 8,
  parameter bit WRAP = 1'b1
) (
  input logic                  i_clk,
  input logic                  i_rst,
  gray_up_down_counter_if.slave bus
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] r_bin;
  logic [N-1:0] r_g;
  logic         r_tc;

  logic         w_at_limit;
  logic [N-1:0] w_step_bin;
  logic [N-1:0] w_next_bin;

  function automatic logic [N-1:0] to_gray(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  always_comb begin
    w_at_limit = bus.up ? (r_bin == '1) : (r_bin == '0);
    w_step_bin = bus.up ? (r_bin + ONE) : (r_bin - ONE);
    w_next_bin = r_bin;
    if (bus.load) begin
      w_next_bin = bus.load_bin;
    end else if (bus.en) begin
      // Saturating mode holds at the limit; wrapping mode relies on modulo-2^N arithmetic.
      w_next_bin = (w_at_limit && !WRAP) ? r_bin : w_step_bin;
    end
  end

  // g is encoded from the next binary value so both registers change on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bin <= '0;
      r_g   <= '0;
      r_tc  <= 1'b0;
    end else begin
      r_bin <= w_next_bin;
      r_g   <= to_gray(w_next_bin);
      r_tc  <= !bus.load && bus.en && w_at_limit;
    end
  end

  assign bus.bin = r_bin;
  assign bus.g   = r_g;
  assign bus.tc  = r_tc;

endmodule

// File: tb/tb_gray_up_down_counter.sv
// Directed and soak checks for gray_up_down_counter in wrapping and saturating configurations.
module tb_gray_up_down_counter;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  gray_up_down_counter_if #(.N(8)) bus_w ();
  gray_up_down_counter_if #(.N(8)) bus_s ();

  gray_up_down_counter #(.N(8), .WRAP(1'b1)) u_wrap (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_w)
  );

  gray_up_down_counter #(.N(8), .WRAP(1'b0)) u_sat (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_w(input string tag, input logic [7:0] b, input logic [7:0] gg, input logic t);
    check({tag, ".bin"}, bus_w.bin, b);
    check({tag, ".g"},   bus_w.g,   gg);
    check({tag, ".tc"},  8'(bus_w.tc), 8'(t));
  endtask

  task automatic chk_s(input string tag, input logic [7:0] b, input logic [7:0] gg, input logic t);
    check({tag, ".bin"}, bus_s.bin, b);
    check({tag, ".g"},   bus_s.g,   gg);
    check({tag, ".tc"},  8'(bus_s.tc), 8'(t));
  endtask

  initial begin
    logic [7:0] m_bin;
    logic [7:0] prev_g;
    logic       m_tc;
    logic       en_r;
    logic       up_r;

    rst = 1'b1;
    bus_w.en = 1'b1; bus_w.up = 1'b1; bus_w.load = 1'b0; bus_w.load_bin = 8'h00;
    bus_s.en = 1'b0; bus_s.up = 1'b1; bus_s.load = 1'b0; bus_s.load_bin = 8'h00;

    // Reset held with en high, then count up four times.
    step(); chk_w("rst0", 8'h00, 8'h00, 1'b0);
    step(); chk_w("rst1", 8'h00, 8'h00, 1'b0);
    chk_s("rst_sat", 8'h00, 8'h00, 1'b0);
    rst = 1'b0;
    step(); chk_w("up1", 8'h01, 8'h01, 1'b0);
    step(); chk_w("up2", 8'h02, 8'h03, 1'b0);
    step(); chk_w("up3", 8'h03, 8'h02, 1'b0);
    step(); chk_w("up4", 8'h04, 8'h06, 1'b0);

    // Load, then load with en high in the same cycle.
    bus_w.en = 1'b0; bus_w.load = 1'b1; bus_w.load_bin = 8'h24;
    step(); chk_w("load24", 8'h24, 8'h36, 1'b0);
    bus_w.en = 1'b1; bus_w.load_bin = 8'h8D;
    step(); chk_w("load8d", 8'h8D, 8'hCB, 1'b0);

    // Wrap up from all-ones.
    bus_w.load_bin = 8'hFF;
    step(); chk_w("loadff", 8'hFF, 8'h80, 1'b0);
    bus_w.load = 1'b0; bus_w.up = 1'b1;
    step(); chk_w("wrapup", 8'h00, 8'h00, 1'b1);
    step(); chk_w("wrapup_next", 8'h01, 8'h01, 1'b0);

    // Wrap down from zero.
    bus_w.load = 1'b1; bus_w.load_bin = 8'h00;
    step(); chk_w("load00", 8'h00, 8'h00, 1'b0);
    bus_w.load = 1'b0; bus_w.up = 1'b0;
    step(); chk_w("wrapdn", 8'hFF, 8'h80, 1'b1);
    step(); chk_w("wrapdn_next", 8'hFE, 8'h81, 1'b0);

    // Saturating instance: hold at the top with tc asserted every cycle.
    bus_w.en = 1'b0;
    bus_s.load = 1'b1; bus_s.load_bin = 8'hFF;
    step(); chk_s("sat_load", 8'hFF, 8'h80, 1'b0);
    bus_s.load = 1'b0; bus_s.en = 1'b1; bus_s.up = 1'b1;
    step(); chk_s("sat1", 8'hFF, 8'h80, 1'b1);
    step(); chk_s("sat2", 8'hFF, 8'h80, 1'b1);
    step(); chk_s("sat3", 8'hFF, 8'h80, 1'b1);
    bus_s.up = 1'b0;
    step(); chk_s("sat_dn", 8'hFE, 8'h81, 1'b0);
    bus_s.en = 1'b0;
    step(); chk_s("sat_hold", 8'hFE, 8'h81, 1'b0);

    // Random soak on the wrapping instance against a reference model.
    m_bin  = 8'hFE;
    prev_g = 8'h81;
    for (int i = 0; i < 1000; i++) begin
      en_r = 1'($urandom_range(0, 1));
      up_r = 1'($urandom_range(0, 1));
      bus_w.en = en_r;
      bus_w.up = up_r;
      rst = (i == 500);
      if (rst) begin
        m_bin = 8'h00;
        m_tc  = 1'b0;
      end else if (en_r) begin
        m_tc  = up_r ? (m_bin == 8'hFF) : (m_bin == 8'h00);
        m_bin = up_r ? m_bin + 8'd1 : m_bin - 8'd1;
      end else begin
        m_tc = 1'b0;
      end
      step();
      chk_w("soak", m_bin, m_bin ^ (m_bin >> 1), m_tc);
      if (en_r && !rst) begin
        check("soak.onebit", 8'($countones(bus_w.g ^ prev_g)), 8'd1);
      end
      prev_g = bus_w.g;
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
